// File: rtl/decode_in_capture_buffer.sv
// decode_in_capture_buffer
//  Trace/capture stage beside the LC3 decode stage. Every clock edge where
//  enable_decode & capture_en is high, the {instr_dout, npc_in} pair is queued
//  into a DEPTH-entry first-word-fall-through FIFO. Pushes that find the FIFO
//  full (with no simultaneous pop) are dropped and counted in a saturating
//  overflow counter. rd_* are registered and always present the head entry;
//  when the FIFO is empty they keep the last value they showed.
//  Optional feature macro: DECODE_IN_CAP_TSTAMP_EN adds a free-running cycle
//  counter, a per-entry timestamp and the rd_tstamp output.
module decode_in_capture_buffer #(
  parameter int INSTR_W = 16,
  parameter int NPC_W   = 16,
  parameter int DEPTH   = 8,
  parameter int OVF_W   = 8,
  parameter int TS_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_decode,
  input  logic [INSTR_W-1:0]         instr_dout,
  input  logic [NPC_W-1:0]           npc_in,
  input  logic                       capture_en,
  input  logic                       flush,
  input  logic                       rd_en,
`ifdef DECODE_IN_CAP_TSTAMP_EN
  output logic [TS_W-1:0]            rd_tstamp,
`endif
  output logic                       rd_valid,
  output logic [INSTR_W-1:0]         rd_instr,
  output logic [NPC_W-1:0]           rd_npc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic [OVF_W-1:0]           overflow_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [OVF_W-1:0] OVF_MAX = {OVF_W{1'b1}};

  // Storage and state
  logic [INSTR_W-1:0] mem_instr_q [DEPTH];
  logic [NPC_W-1:0]   mem_npc_q   [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rd_valid_q, rd_valid_d;
  logic               full_q, full_d;
  logic [INSTR_W-1:0] rd_instr_q, rd_instr_d;
  logic [NPC_W-1:0]   rd_npc_q, rd_npc_d;
  logic [OVF_W-1:0]   ovf_q, ovf_d;

  // Handshake qualifiers
  logic push_s;
  logic pop_s;
  logic full_now_s;
  logic wr_acc_s;
  logic drop_s;
  logic head_from_bus_s;

`ifdef DECODE_IN_CAP_TSTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] mem_ts_q [DEPTH];
  logic [TS_W-1:0] rd_tstamp_q, rd_tstamp_d;
`endif

  // Decode the push/pop/drop conditions for this edge.
  always_comb begin
    push_s     = enable_decode & capture_en;
    pop_s      = rd_en & rd_valid_q;
    full_now_s = (count_q == DEPTH_C);
    // A full FIFO still accepts a push when a pop frees the head slot at the same edge.
    wr_acc_s   = push_s & (~full_now_s | pop_s);
    drop_s     = push_s & full_now_s & ~pop_s;
  end

  // Next-state for pointers, occupancy, head read-out and overflow counter.
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    rd_valid_d      = rd_valid_q;
    full_d          = full_q;
    rd_instr_d      = rd_instr_q;
    rd_npc_d        = rd_npc_q;
    ovf_d           = ovf_q;
    head_from_bus_s = 1'b0;
`ifdef DECODE_IN_CAP_TSTAMP_EN
    rd_tstamp_d     = rd_tstamp_q;
`endif
    if (flush) begin
      // Flush wins over push and pop; read-out registers keep their last value.
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      count_d    = {CNT_W{1'b0}};
      rd_valid_d = 1'b0;
      full_d     = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      rd_valid_d = (count_d != {CNT_W{1'b0}});
      full_d     = (count_d == DEPTH_C);
      if (drop_s && (ovf_q != OVF_MAX)) begin
        ovf_d = ovf_q + OVF_W'(1);
      end else begin
        ovf_d = ovf_q;
      end
      // The new head is the word being written this edge when it lands exactly
      // at the new read pointer (empty FIFO, or last entry popped while pushing).
      head_from_bus_s = wr_acc_s & (rd_ptr_d == wr_ptr_q);
      if (count_d != {CNT_W{1'b0}}) begin
        if (head_from_bus_s) begin
          rd_instr_d = instr_dout;
          rd_npc_d   = npc_in;
`ifdef DECODE_IN_CAP_TSTAMP_EN
          rd_tstamp_d = ts_q;
`endif
        end else begin
          rd_instr_d = mem_instr_q[rd_ptr_d];
          rd_npc_d   = mem_npc_q[rd_ptr_d];
`ifdef DECODE_IN_CAP_TSTAMP_EN
          rd_tstamp_d = mem_ts_q[rd_ptr_d];
`endif
        end
      end else begin
        rd_instr_d = rd_instr_q;
        rd_npc_d   = rd_npc_q;
      end
    end
  end

  // Entry storage: written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (wr_acc_s && !flush) begin
      mem_instr_q[wr_ptr_q] <= instr_dout;
      mem_npc_q[wr_ptr_q]   <= npc_in;
`ifdef DECODE_IN_CAP_TSTAMP_EN
      mem_ts_q[wr_ptr_q]    <= ts_q;
`endif
    end
  end

  // Control and read-out registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      rd_instr_q <= {INSTR_W{1'b0}};
      rd_npc_q   <= {NPC_W{1'b0}};
      ovf_q      <= {OVF_W{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      rd_instr_q <= rd_instr_d;
      rd_npc_q   <= rd_npc_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef DECODE_IN_CAP_TSTAMP_EN
  // Free-running cycle counter and registered head timestamp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q        <= {TS_W{1'b0}};
      rd_tstamp_q <= {TS_W{1'b0}};
    end else begin
      ts_q        <= ts_q + TS_W'(1);
      rd_tstamp_q <= rd_tstamp_d;
    end
  end

  assign rd_tstamp = rd_tstamp_q;
`endif

  assign rd_valid     = rd_valid_q;
  assign rd_instr     = rd_instr_q;
  assign rd_npc       = rd_npc_q;
  assign count        = count_q;
  assign full         = full_q;
  assign overflow_cnt = ovf_q;

endmodule
